// File: rtl/spike_window_counter.sv
// spike_window_counter
//   Turns a LIF neuron's spike train into a rate value. Over a programmable
//   window of enabled (execute) cycles it counts spikes (saturating) and tracks
//   the peak unsigned membrane value. It then presents {count, peak} on a
//   valid/ready result register. Windows run either one-shot or back-to-back.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               begin a window (only acted on while idle)
//   stop                abort the running window, no result (only while running)
//   continuous          sampled at start: auto-restart after each window
//   window_len          enabled samples per window, sampled at start (0 = 2**WINDOW_BITS)
//   enable              execute strobe; a sample is taken only when high
//   spike, membrane     neuron outputs being observed
//   out_count/out_peak  result of the last completed window
//   out_valid/out_ready result handshake
//   busy                window in progress
//   overrun             sticky: an unconsumed result was overwritten
module spike_window_counter #(
  parameter int COUNT_BITS    = 8,
  parameter int WINDOW_BITS   = 8,
  parameter int MEMBRANE_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [WINDOW_BITS-1:0]   window_len,
  input  logic                     enable,
  input  logic                     spike,
  input  logic [MEMBRANE_BITS-1:0] membrane,
  output logic [COUNT_BITS-1:0]    out_count,
  output logic [MEMBRANE_BITS-1:0] out_peak,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};

  state_t                   state_q, state_d;
  logic [WINDOW_BITS:0]     remaining_q, remaining_d;
  logic [WINDOW_BITS:0]     len_q, len_d;
  logic                     cont_q, cont_d;
  logic [COUNT_BITS-1:0]    acc_count_q, acc_count_d;
  logic [MEMBRANE_BITS-1:0] acc_peak_q, acc_peak_d;
  logic [COUNT_BITS-1:0]    out_count_q, out_count_d;
  logic [MEMBRANE_BITS-1:0] out_peak_q, out_peak_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  // Per-sample values including the current cycle's spike/membrane, so the
  // completing sample is part of the result.
  logic [COUNT_BITS-1:0]    sample_count;
  logic [MEMBRANE_BITS-1:0] sample_peak;
  logic                     done;
  logic [WINDOW_BITS:0]     start_len;

  always_comb begin
    sample_count = (acc_count_q == COUNT_MAX) ? acc_count_q
                                              : acc_count_q + COUNT_BITS'(spike);
    sample_peak  = (membrane > acc_peak_q) ? membrane : acc_peak_q;
    // A zero length encodes the full 2**WINDOW_BITS samples via the extra bit.
    start_len    = (window_len == '0) ? {1'b1, {WINDOW_BITS{1'b0}}}
                                      : {1'b0, window_len};
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    cont_d      = cont_q;
    acc_count_d = acc_count_q;
    acc_peak_d  = acc_peak_q;
    out_count_d = out_count_q;
    out_peak_d  = out_peak_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = start_len;
          len_d       = start_len;
          cont_d      = continuous;
          acc_count_d = '0;
          acc_peak_d  = '0;
          overrun_d   = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // stop wins over a completing sample in the same cycle
        if (stop) begin
          state_d = IDLE;
        end else if (enable) begin
          if (remaining_q == (WINDOW_BITS+1)'(1)) begin
            done = 1'b1;
            if (cont_q) begin
              acc_count_d = '0;
              acc_peak_d  = '0;
              remaining_d = len_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            acc_count_d = sample_count;
            acc_peak_d  = sample_peak;
            remaining_d = remaining_q - (WINDOW_BITS+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Result register: a new result always loads; it only counts as an
    // overrun when the previous one is neither consumed nor being consumed.
    if (done) begin
      out_count_d = sample_count;
      out_peak_d  = sample_peak;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      len_q       <= '0;
      cont_q      <= 1'b0;
      acc_count_q <= '0;
      acc_peak_q  <= '0;
      out_count_q <= '0;
      out_peak_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      cont_q      <= cont_d;
      acc_count_q <= acc_count_d;
      acc_peak_q  <= acc_peak_d;
      out_count_q <= out_count_d;
      out_peak_q  <= out_peak_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_count = out_count_q;
  assign out_peak  = out_peak_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == RUN);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_window_counter.sv
// tb_spike_window_counter
//   Directed vectors with hand-computed expectations for spike_window_counter.
//   Inputs change 1 ns after a rising edge; outputs are checked at the same
//   point, so each check sees the state produced by the preceding edge.
module tb_spike_window_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] window_len;
  logic       enable;
  logic       spike;
  logic [6:0] membrane;
  logic [7:0] out_count;
  logic [6:0] out_peak;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  spike_window_counter #(
    .COUNT_BITS   (8),
    .WINDOW_BITS  (8),
    .MEMBRANE_BITS(7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .continuous(continuous),
    .window_len(window_len),
    .enable    (enable),
    .spike     (spike),
    .membrane  (membrane),
    .out_count (out_count),
    .out_peak  (out_peak),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // one rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic en, input logic sp, input logic [6:0] mem);
    enable   = en;
    spike    = sp;
    membrane = mem;
    step();
  endtask

  task automatic start_window(input logic [7:0] len, input logic cont);
    window_len = len;
    continuous = cont;
    start      = 1'b1;
    enable     = 1'b0;
    step();
    start      = 1'b0;
  endtask

  task automatic accept();
    enable    = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [6:0] mem_vec [6];

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    window_len = '0; enable = 1'b0; spike = 1'b0; membrane = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_count", out_count, 0);
    check("rst_peak", out_peak, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // 1: len=4, spikes 1,0,1,1, membrane 3,9,2,5
    start_window(8'd4, 1'b0);
    check("t1_busy", busy, 1);
    sample(1, 1, 7'd3);
    sample(1, 0, 7'd9);
    sample(1, 1, 7'd2);
    check("t1_valid_early", out_valid, 0);
    sample(1, 1, 7'd5);
    check("t1_valid", out_valid, 1);
    check("t1_count", out_count, 3);
    check("t1_peak", out_peak, 9);
    check("t1_busy_drop", busy, 0);
    sample(0, 0, 7'd0);
    check("t1_hold_valid", out_valid, 1);
    check("t1_hold_count", out_count, 3);
    accept();
    check("t1_accept", out_valid, 0);

    // 2: len=3, enable 1,0,0,1,0,1, spike always 1; disabled membranes ignored
    mem_vec = '{7'd5, 7'd50, 7'd40, 7'd7, 7'd100, 7'd6};
    start_window(8'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t2_valid_early", out_valid, 0);
      sample((i == 0) || (i == 3) || (i == 5), 1'b1, mem_vec[i]);
    end
    check("t2_valid", out_valid, 1);
    check("t2_count", out_count, 3);
    check("t2_peak", out_peak, 7);
    accept();

    // 3: len=0 -> 256 samples, spike always 1 -> count saturates at 255
    start_window(8'd0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        check("t3_valid_early", out_valid, 0);
        check("t3_busy_early", busy, 1);
      end
      sample(1'b1, 1'b1, 7'(i));
    end
    check("t3_valid", out_valid, 1);
    check("t3_count_sat", out_count, 255);
    check("t3_peak", out_peak, 127);
    accept();

    // 4: continuous, len=2, out_ready low -> overwrite sets overrun
    start_window(8'd2, 1'b1);
    sample(1, 1, 7'd3);
    sample(1, 0, 7'd4);
    check("t4_w1_valid", out_valid, 1);
    check("t4_w1_count", out_count, 1);
    check("t4_w1_peak", out_peak, 4);
    check("t4_w1_overrun", overrun, 0);
    check("t4_w1_busy", busy, 1);
    sample(1, 1, 7'd8);
    sample(1, 1, 7'd2);
    check("t4_w2_count", out_count, 2);
    check("t4_w2_peak", out_peak, 8);
    check("t4_w2_overrun", overrun, 1);
    accept();
    check("t4_accept", out_valid, 0);
    sample(0, 0, 7'd0);
    check("t4_stay_low", out_valid, 0);
    sample(1, 0, 7'd1);
    check("t4_w3_early", out_valid, 0);
    sample(1, 0, 7'd1);
    check("t4_w3_valid", out_valid, 1);
    check("t4_w3_count", out_count, 0);
    check("t4_w3_peak", out_peak, 1);
    check("t4_overrun_sticky", overrun, 1);
    stop = 1'b1;
    sample(0, 0, 7'd0);
    stop = 1'b0;
    check("t4_stop_busy", busy, 0);
    accept();

    // 5: len=5, stop at sample 3 -> no result; start clears overrun
    start_window(8'd5, 1'b0);
    check("t5_overrun_clr", overrun, 0);
    sample(1, 1, 7'd60);
    sample(1, 1, 7'd61);
    stop = 1'b1;
    sample(1, 1, 7'd62);
    stop = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_count_kept", out_count, 0);
    check("t5_peak_kept", out_peak, 1);

    // 5b: reset mid-window clears everything, including a pending result
    start_window(8'd1, 1'b0);
    sample(1, 1, 7'd20);
    check("t5b_valid", out_valid, 1);
    check("t5b_count", out_count, 1);
    start_window(8'd5, 1'b0);
    sample(1, 1, 7'd30);
    reset = 1'b1;
    sample(0, 0, 7'd0);
    reset = 1'b0;
    check("t5b_rst_count", out_count, 0);
    check("t5b_rst_peak", out_peak, 0);
    check("t5b_rst_valid", out_valid, 0);
    check("t5b_rst_busy", busy, 0);
    check("t5b_rst_overrun", overrun, 0);

    // 6: continuous, len=1, out_ready held -> fresh result every sample
    start_window(8'd1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample(1'b1, 1'(i % 2), 7'(i * 3 + 1));
      check("t6_valid", out_valid, 1);
      check("t6_count", out_count, i % 2);
      check("t6_peak", out_peak, i * 3 + 1);
      check("t6_overrun", overrun, 0);
    end
    stop = 1'b1;
    sample(0, 0, 7'd0);
    stop = 1'b0;
    check("t6_stop_busy", busy, 0);
    check("t6_drained", out_valid, 0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
